adc_trig_capture: RTL and testbench

Threshold-triggered capture stage that sits directly downstream of the sample-delay pipeline in the ADC data path. It watches the live (undelayed) ADC stream for a rising threshold crossing. On a trigger it captures a fixed-length window of the delayed stream, so the window contains pre-trigger history. Captured samples are buffered in an internal FIFO and drained through a valid/ready interface toward the comm/packetizer logic.

---
 rtl/adc_trig_capture_if.sv | 21 ++
 rtl/adc_trig_capture.sv | 200 ++++++++++++++++++++
 tb/tb_adc_trig_capture.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_trig_capture_if.sv
// adc_trig_capture_if -- valid/ready stream carrying captured ADC samples
// with first/last window markers, from the capture stage toward the packetizer.
interface adc_trig_capture_if #(
   parameter int P_WIDTH = 12
);
   logic [P_WIDTH-1:0] out_data;
   logic               out_first;
   logic               out_last;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output out_data, out_first, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_first, out_last, out_valid,
      output out_ready
   );
endinterface

// File: rtl/adc_trig_capture.sv
// adc_trig_capture -- threshold-triggered window capture of the delayed ADC
// stream. A rising crossing on the live stream starts a P_LEN-sample window
// taken from the delayed stream, buffered in a FIFO and drained over a
// valid/ready stream.
// Optional feature: define ADC_TRIG_SELF_REARM_EN to re-arm automatically
// after the holdoff period instead of returning to IDLE.
module adc_trig_capture #(
   parameter int P_WIDTH   = 12,
   parameter int P_LEN     = 16,
   parameter int P_HOLDOFF = 8,
   parameter int P_FIFO_AW = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [P_WIDTH-1:0] live_in,
   input  logic [P_WIDTH-1:0] dly_in,
   input  logic [P_WIDTH-1:0] thresh,
   input  logic               arm,
   adc_trig_capture_if.master out_if,
   output logic               busy,
   output logic               armed,
   output logic               ovf,
   output logic [15:0]        trig_cnt
);

   localparam int DEPTH = 2 ** P_FIFO_AW;
   localparam int FW    = P_WIDTH + 2;   // {first, last, data}

   localparam logic [7:0]         LAST_IDX  = 8'(P_LEN - 1);
   localparam logic [7:0]         HOLD_LAST = (P_HOLDOFF > 0) ? 8'(P_HOLDOFF - 1) : 8'd0;
   localparam logic [P_FIFO_AW:0] FULL_CNT  = (P_FIFO_AW + 1)'(DEPTH);
   localparam logic [P_FIFO_AW:0] CNT_ONE   = (P_FIFO_AW + 1)'(1);
   localparam logic [P_FIFO_AW-1:0] PTR_ONE = P_FIFO_AW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_HOLDOFF
   } state_t;

`ifdef ADC_TRIG_SELF_REARM_EN
   localparam state_t DONE_STATE = S_ARMED;
`else
   localparam state_t DONE_STATE = S_IDLE;
`endif

   state_t             state;
   logic [P_WIDTH-1:0] prev_live;
   logic [7:0]         cap_idx;
   logic [7:0]         hold_cnt;

   logic               crossing;
   logic               wr_req;
   logic [FW-1:0]      wr_word;
   logic               wr_ok;
   logic               rd_xfer;
   logic               load_out;
   logic               fifo_full;

   logic [FW-1:0]        mem [DEPTH];
   logic [P_FIFO_AW-1:0] wr_ptr;
   logic [P_FIFO_AW-1:0] rd_ptr;
   logic [P_FIFO_AW:0]   mem_cnt;
   logic [P_FIFO_AW:0]   total_cnt;
   logic [FW-1:0]        out_word_q;
   logic                 out_valid_q;

   // Previous live sample, kept in every state so crossings are edge-detected.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_live <= '0;
      else        prev_live <= live_in;
   end

   // Crossing detect and selection of the word to be written this cycle.
   // NOTE: every signal gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      crossing = (prev_live < thresh) && (live_in >= thresh);
      wr_req   = 1'b0;
      wr_word  = '0;
      if (state == S_ARMED && crossing) begin
         wr_req  = 1'b1;
         wr_word = {1'b1, 1'b0, dly_in};
      end else if (state == S_CAPTURE) begin
         wr_req  = 1'b1;
         wr_word = {1'b0, (cap_idx == LAST_IDX), dly_in};
      end
   end

   // Occupancy counts the output register too, so the FIFO holds exactly
   // DEPTH words; a consumer read in the same cycle frees a slot for a write.
   assign total_cnt = mem_cnt + {{P_FIFO_AW{1'b0}}, out_valid_q};
   assign fifo_full = (total_cnt == FULL_CNT);
   assign rd_xfer   = out_valid_q && out_if.out_ready;
   assign wr_ok     = wr_req && (!fifo_full || rd_xfer);
   assign load_out  = (mem_cnt != '0) && (!out_valid_q || out_if.out_ready);

   // Control FSM with registered status outputs, trigger counter and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cap_idx  <= '0;
         hold_cnt <= '0;
         busy     <= 1'b0;
         armed    <= 1'b0;
         ovf      <= 1'b0;
         trig_cnt <= '0;
      end else begin
         if (wr_req && !wr_ok) ovf <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (arm) begin
                  state <= S_ARMED;
                  armed <= 1'b1;
                  ovf   <= 1'b0;
               end
            end
            S_ARMED: begin
               if (crossing) begin
                  state   <= S_CAPTURE;
                  armed   <= 1'b0;
                  busy    <= 1'b1;
                  cap_idx <= 8'd1;   // word 0 was written on the trigger cycle
                  if (trig_cnt != 16'hFFFF) trig_cnt <= trig_cnt + 16'd1;
               end
            end
            S_CAPTURE: begin
               if (cap_idx == LAST_IDX) begin
                  if (P_HOLDOFF == 0) begin
                     state <= DONE_STATE;
                     busy  <= 1'b0;
                     armed <= (DONE_STATE == S_ARMED);
                  end else begin
                     state    <= S_HOLDOFF;
                     hold_cnt <= '0;
                  end
               end else begin
                  cap_idx <= cap_idx + 8'd1;
               end
            end
            S_HOLDOFF: begin
               if (hold_cnt == HOLD_LAST) begin
                  state <= DONE_STATE;
                  busy  <= 1'b0;
                  armed <= (DONE_STATE == S_ARMED);
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage array, written only when a slot is available.
   // NOTE: the array has no reset; only pointers and counts are reset, which
   // empties the FIFO without clearing every entry.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_word;
   end

   // FIFO pointers and stored-word count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
      end else begin
         if (wr_ok)    wr_ptr <= wr_ptr + PTR_ONE;
         if (load_out) rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({wr_ok, load_out})
            2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
            2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
            default: mem_cnt <= mem_cnt;
         endcase
      end
   end

   // Output register: refills whenever empty or being consumed; holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_word_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (load_out) begin
         out_word_q  <= mem[rd_ptr];
         out_valid_q <= 1'b1;
      end else if (rd_xfer) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_if.out_data  = out_word_q[P_WIDTH-1:0];
   assign out_if.out_last  = out_word_q[FW-2];
   assign out_if.out_first = out_word_q[FW-1];
   assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture -- directed bench for adc_trig_capture (P_FIFO_AW=3).
// The delayed stream is modelled as the live stream delayed by 4 cycles.
module tb_adc_trig_capture;

   localparam int W = 12;
`ifdef ADC_TRIG_SELF_REARM_EN
   localparam bit REARM = 1'b1;
`else
   localparam bit REARM = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  live_in, dly_in, thresh;
   logic          arm;
   logic          busy, armed, ovf;
   logic [15:0]   trig_cnt;

   adc_trig_capture_if #(.P_WIDTH(W)) out_if ();

   adc_trig_capture #(
      .P_WIDTH(W), .P_LEN(16), .P_HOLDOFF(8), .P_FIFO_AW(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .live_in(live_in), .dly_in(dly_in),
      .thresh(thresh), .arm(arm), .out_if(out_if.master), .busy(busy),
      .armed(armed), .ovf(ovf), .trig_cnt(trig_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0]   hist [4];
   logic [W-1:0]   dly_log [0:1023];
   int             cyc = 0;
   logic [W+1:0]   got [$];
   logic           stall_seen = 1'b0;
   logic [W+1:0]   stall_word;
   int             exp_trig = 0;
   int             trig;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Present one live sample (and the 4-cycle-delayed sample) for the next edge.
   task automatic tick(input logic [W-1:0] lv, input logic a);
      live_in = lv;
      arm     = a;
      dly_in  = hist[3];
      dly_log[cyc] = hist[3];
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = lv;
      @(posedge clk); #1;
      arm = 1'b0;
      cyc++;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_valid"}, 32'(out_if.out_valid), 32'd0);
      check({pfx, "_data"},  32'(out_if.out_data),  32'd0);
      check({pfx, "_first"}, 32'(out_if.out_first), 32'd0);
      check({pfx, "_last"},  32'(out_if.out_last),  32'd0);
      check({pfx, "_busy"},  32'(busy),             32'd0);
      check({pfx, "_armed"}, 32'(armed),            32'd0);
      check({pfx, "_ovf"},   32'(ovf),              32'd0);
      check({pfx, "_trig"},  32'(trig_cnt),         32'd0);
   endtask

   function automatic logic [W+1:0] word_at(input int k);
      if (k < got.size()) return got[k];
      return '1;
   endfunction

   // Collect transferred words; verify the word holds while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check("hold_valid", 32'(out_if.out_valid), 32'd1);
            check("hold_word",
                  32'({out_if.out_first, out_if.out_last, out_if.out_data}),
                  32'(stall_word));
         end
         if (out_if.out_valid && out_if.out_ready)
            got.push_back({out_if.out_first, out_if.out_last, out_if.out_data});
         stall_seen = out_if.out_valid && !out_if.out_ready;
         stall_word = {out_if.out_first, out_if.out_last, out_if.out_data};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      rst_n = 1'b0; live_in = '0; dly_in = '0; thresh = 12'd100; arm = 1'b0;
      out_if.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_reset_vals("rst0");

      // Basic window
      tick(10, 0); tick(20, 0); tick(30, 0);
      tick(40, 1);
      check("a_armed", 32'(armed), 32'd1);
      tick(90, 0); tick(95, 0);
      trig = cyc;
      tick(105, 0);
      exp_trig++;
      check("a_busy", 32'(busy), 32'd1);
      check("a_trig", 32'(trig_cnt), 32'(exp_trig));
      for (int i = 0; i < 40; i++) tick(W'(106 + i), 0);
      check("a_count", 32'(got.size()), 32'd16);
      for (int k = 0; k < 16; k++)
         check($sformatf("a_word%0d", k), 32'(word_at(k)),
               32'({(k == 0), (k == 15), dly_log[trig + k]}));
      check("a_busy_end", 32'(busy), 32'd0);
      check("a_armed_end", 32'(armed), 32'(REARM));

      // Level above threshold does not trigger; arm in CAPTURE and crossing in HOLDOFF ignored
      got.delete();
      tick(200, 1);
      for (int i = 0; i < 10; i++) tick(200, 0);
      check("b_level_trig", 32'(trig_cnt), 32'(exp_trig));
      check("b_armed", 32'(armed), 32'd1);
      tick(50, 0);
      trig = cyc;
      tick(150, 0);
      exp_trig++;
      check("b_trig", 32'(trig_cnt), 32'(exp_trig));
      tick(150, 1);
      check("b_arm_cap_busy", 32'(busy), 32'd1);
      check("b_arm_cap_armed", 32'(armed), 32'd0);
      for (int i = 0; i < 14; i++) tick(150, 0);
      tick(50, 0); tick(150, 0);
      check("b_holdoff_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 20; i++) tick(150, 0);
      check("b_holdoff_trig", 32'(trig_cnt), 32'(exp_trig));
      check("b_count", 32'(got.size()), 32'd16);
      check("b_word0", 32'(word_at(0)), 32'({2'b10, dly_log[trig]}));
      check("b_armed_end", 32'(armed), 32'(REARM));

      // Two crossings far apart from a single arm
      got.delete();
      tick(50, 1);
      tick(150, 0);
      exp_trig++;
      for (int i = 0; i < 29; i++) tick(150, 0);
      tick(50, 0); tick(150, 0);
      if (REARM) exp_trig++;
      for (int i = 0; i < 40; i++) tick(150, 0);
      check("c_trig", 32'(trig_cnt), 32'(exp_trig));
      check("c_count", 32'(got.size()), REARM ? 32'd32 : 32'd16);
      check("c_armed", 32'(armed), 32'(REARM));
      check("c_busy", 32'(busy), 32'd0);

      // Backpressure and overflow
      got.delete();
      out_if.out_ready = 1'b0;
      tick(50, 1);
      trig = cyc;
      tick(150, 0);
      exp_trig++;
      for (int i = 0; i < 30; i++) tick(150, 0);
      check("d_ovf", 32'(ovf), 32'd1);
      check("d_valid", 32'(out_if.out_valid), 32'd1);
      check("d_no_xfer", 32'(got.size()), 32'd0);
      check("d_trig", 32'(trig_cnt), 32'(exp_trig));
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick(150, 0);
      check("d_count", 32'(got.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         check($sformatf("d_word%0d", k), 32'(word_at(k)),
               32'({(k == 0), 1'b0, dly_log[trig + k]}));
      check("d_valid_end", 32'(out_if.out_valid), 32'd0);
      tick(50, 1);
      check("d_ovf_after_arm", 32'(ovf), REARM ? 32'd1 : 32'd0);
      check("d_armed_after_arm", 32'(armed), 32'd1);

      // Reset mid-capture with 3 words queued
      got.delete();
      out_if.out_ready = 1'b0;
      tick(150, 0);
      tick(150, 0); tick(150, 0);
      check("e_busy_pre", 32'(busy), 32'd1);
      check("e_valid_pre", 32'(out_if.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rst_mid");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick(150, 0);
      check_reset_vals("rst_post");
      check("e_empty", 32'(got.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
